// File: rtl/spart_bus_arbiter.sv
// Single owner of the SPART bus: programs the baud divisor after reset, then
// services RX reads (priority) and round-robin TX writes from two clients.
module spart_bus_arbiter #(
    parameter logic [15:0] BAUD_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tx_valid,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_owner,
    output logic       cfg_done,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] dbus_out,
    output logic       dbus_oe,
    input  logic [7:0] dbus_in,
    input  logic       rda,
    input  logic       tbr
);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, GAP} state_t;

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   pick;

    // Both requesting: the client that did not win last time; otherwise the sole requester.
    always_comb begin
        pick = tx_valid[1];
        if (tx_valid == 2'b11) pick = ~last_gnt;
    end

    assign tx_ready = (state == WR) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    // Bus outputs are loaded on the edge that enters an access, so they are
    // valid for exactly the cycle spent in RD/WR (or the cycle after each CFG state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CFG_LO;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            iocs     <= 1'b0;
            iorw     <= 1'b0;
            ioaddr   <= 2'b00;
            dbus_out <= 8'h00;
            dbus_oe  <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_owner <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            iocs     <= 1'b0;
            iorw     <= 1'b0;
            ioaddr   <= 2'b00;
            dbus_out <= 8'h00;
            dbus_oe  <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                CFG_LO: begin
                    iocs     <= 1'b1;
                    ioaddr   <= 2'b10;
                    dbus_out <= BAUD_DIV[7:0];
                    dbus_oe  <= 1'b1;
                    state    <= CFG_HI;
                end
                CFG_HI: begin
                    iocs     <= 1'b1;
                    ioaddr   <= 2'b11;
                    dbus_out <= BAUD_DIV[15:8];
                    dbus_oe  <= 1'b1;
                    state    <= GAP;
                end
                IDLE: begin
                    // First IDLE after configuration only raises cfg_done; requests wait.
                    if (!cfg_done) begin
                        cfg_done <= 1'b1;
                    end else if (rda) begin
                        iocs  <= 1'b1;
                        iorw  <= 1'b1;
                        state <= RD;
                    end else if (tbr && (tx_valid != 2'b00)) begin
                        gnt      <= pick;
                        iocs     <= 1'b1;
                        dbus_out <= pick ? tx_data1 : tx_data0;
                        dbus_oe  <= 1'b1;
                        state    <= WR;
                    end
                end
                RD: begin
                    rx_data  <= dbus_in;
                    rx_valid <= 1'b1;
                    rx_owner <= last_gnt;
                    state    <= GAP;
                end
                WR: begin
                    last_gnt <= gnt;
                    state    <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= CFG_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Bench for spart_bus_arbiter: directed vector table, hand sequences for
// configuration/starvation/reset, and a randomized run against a transaction model.
module tb_spart_bus_arbiter;

    localparam logic [15:0] DIV = 16'h0145;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tx_valid;
    logic [7:0] tx_data0, tx_data1;
    logic [1:0] tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_owner;
    logic       cfg_done;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] dbus_out;
    logic       dbus_oe;
    logic [7:0] dbus_in;
    logic       rda, tbr;

    int n_checks = 0;
    int n_errors = 0;

    spart_bus_arbiter #(.BAUD_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_owner(rx_owner),
        .cfg_done(cfg_done), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .dbus_out(dbus_out),
        .dbus_oe(dbus_oe), .dbus_in(dbus_in), .rda(rda), .tbr(tbr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rda;
        logic       tbr;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] din;
        logic       e_iocs;
        logic       e_iorw;
        logic [7:0] e_dout;
        logic [1:0] e_rdy;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic       e_rxo;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        tx_valid = 2'b00; tx_data0 = 8'h00; tx_data1 = 8'h00;
        dbus_in = 8'h00; rda = 1'b0; tbr = 1'b0;
    endtask

    // Expects the two divisor writes, a quiet cycle, then cfg_done.
    task automatic config_seq();
        tick();
        chk("cfg_lo_ctl", {iocs, iorw, ioaddr, dbus_oe, cfg_done}, {1'b1, 1'b0, 2'b10, 1'b1, 1'b0});
        chk("cfg_lo_data", dbus_out, DIV[7:0]);
        tick();
        chk("cfg_hi_ctl", {iocs, iorw, ioaddr, dbus_oe, cfg_done}, {1'b1, 1'b0, 2'b11, 1'b1, 1'b0});
        chk("cfg_hi_data", dbus_out, DIV[15:8]);
        tick();
        chk("cfg_gap", {iocs, dbus_oe, cfg_done}, 3'b000);
        tick();
        chk("cfg_done", {iocs, cfg_done}, 2'b01);
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {iocs, iorw, ioaddr, dbus_out, dbus_oe, tx_ready, rx_valid, rx_data, rx_owner, cfg_done},
            32'h0);
        @(negedge clk);
        rst = 1'b0;
        config_seq();
    endtask

    // Randomized-run reference: accesses are transactions; a decision is taken
    // only once two non-access cycles have elapsed since the previous access.
    int       since;
    int       prev_kind;
    bit       mlast;
    int       kind;
    bit       g;
    logic       p_rda, p_tbr;
    logic [1:0] p_v;
    logic [7:0] p_d0, p_d1, p_din;
    logic [7:0] e_dout;
    logic [1:0] e_rdy;
    logic       e_rxv;

    initial begin
        rst = 1'b1;
        zero_inputs();

        // Table: starts in IDLE right after configuration, last grant = client 1.
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'hA5, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 8'h11, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 8'h22, 2'b10, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 8'h11, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 2'b01, 8'h11, 8'h22, 8'h5A, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 2'b01, 8'h11, 8'h22, 8'h5A, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'h5A, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'b01, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'b01, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 8'h11, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            rda = tbl[i].rda; tbr = tbl[i].tbr; tx_valid = tbl[i].v;
            tx_data0 = tbl[i].d0; tx_data1 = tbl[i].d1; dbus_in = tbl[i].din;
            tick();
            chk($sformatf("vec%0d_ctl", i),
                {iocs, iorw, ioaddr, dbus_oe, tx_ready, rx_valid},
                {tbl[i].e_iocs, tbl[i].e_iorw, 2'b00, tbl[i].e_iocs & ~tbl[i].e_iorw,
                 tbl[i].e_rdy, tbl[i].e_rxv});
            if (tbl[i].e_iocs && !tbl[i].e_iorw) chk($sformatf("vec%0d_dout", i), dbus_out, tbl[i].e_dout);
            if (tbl[i].e_rxv) chk($sformatf("vec%0d_rx", i), {rx_data, rx_owner}, {tbl[i].e_rxd, tbl[i].e_rxo});
        end

        // tbr low blocks writes indefinitely; the held request goes out once tbr rises.
        zero_inputs();
        tx_valid = 2'b10; tx_data1 = 8'h22;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("tbr_low_idle", {iocs, tx_ready}, 3'b000);
        end
        tbr = 1'b1;
        tick();
        chk("tbr_rise_write", {iocs, iorw, dbus_oe, tx_ready, dbus_out}, {3'b101, 2'b10, 8'h22});

        // Reset in the middle of a write cycle.
        tx_valid = 2'b01; tx_data0 = 8'h11;
        tick();
        tick();
        tick();
        chk("pre_rst_write", {iocs, tx_ready, dbus_out}, {1'b1, 2'b01, 8'h11});
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_write", {iocs, dbus_oe, tx_ready, cfg_done, rx_valid}, 5'b00000);
        zero_inputs();
        @(negedge clk);
        rst = 1'b0;
        config_seq();

        // Randomized run against the transaction model.
        do_reset();
        since = 2; prev_kind = 0; mlast = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rda = ($urandom_range(0, 3) == 0);
            tbr = 1'($urandom_range(0, 1));
            tx_valid = 2'($urandom);
            tx_data0 = 8'($urandom); tx_data1 = 8'($urandom); dbus_in = 8'($urandom);
            p_rda = rda; p_tbr = tbr; p_v = tx_valid; p_d0 = tx_data0; p_d1 = tx_data1; p_din = dbus_in;
            tick();
            e_rxv = (prev_kind == 1);
            kind = 0;
            if (since >= 2) begin
                if (p_rda) kind = 1;
                else if (p_tbr && p_v != 2'b00) kind = 2;
            end
            e_rdy = 2'b00; e_dout = 8'h00;
            if (kind == 2) begin
                g = (p_v == 2'b11) ? ~mlast : p_v[1];
                e_rdy = g ? 2'b10 : 2'b01;
                e_dout = g ? p_d1 : p_d0;
            end
            chk("rand_ctl", {iocs, iorw, ioaddr, dbus_oe, tx_ready, rx_valid},
                {kind != 0, kind == 1, 2'b00, kind == 2, e_rdy, e_rxv});
            if (kind == 2) begin
                chk("rand_dout", dbus_out, e_dout);
                mlast = g;
            end
            if (e_rxv) chk("rand_rx", {rx_data, rx_owner}, {p_din, mlast});
            since = (kind != 0) ? 0 : since + 1;
            prev_kind = kind;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
